// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS AXI-stream sources into one tagged
// output stream through a single register slice, with per-source beat counters.
module axis_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
) (
  input  logic                                 aclk,
  input  logic                                 resetn,
  input  logic [NUM_INPUTS-1:0]                S00_AXIS_TVALID,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] S00_AXIS_TDATA,
  output logic [NUM_INPUTS-1:0]                S00_AXIS_TREADY,
  output logic                                 M00_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]                M00_AXIS_TDATA,
  output logic [ID_WIDTH-1:0]                  M00_AXIS_TID,
  input  logic                                 M00_AXIS_TREADY,
  input  logic [ID_WIDTH-1:0]                  stat_sel,
  input  logic                                 stat_clear,
  output logic [31:0]                          stat_count
);

  localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NUM_INPUTS - 1);
  localparam logic [ID_WIDTH:0] NUM_EXT  = (ID_WIDTH + 1)'(NUM_INPUTS);

  logic              load_en;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  ptr_q;
  logic              accept;
  logic [31:0]       cnt_all [NUM_INPUTS];

  assign load_en = resetn & (~M00_AXIS_TVALID | M00_AXIS_TREADY);
  assign accept  = load_en & grant_valid;

  // First valid source at or after the pointer, wrapping past the last index.
  always_comb begin
    int unsigned      idx;
    logic [SEL_W-1:0] cand;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      cand = SEL_W'(idx);
      if (!grant_valid && S00_AXIS_TVALID[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    S00_AXIS_TREADY = '0;
    if (grant_valid) S00_AXIS_TREADY[grant] = load_en;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      M00_AXIS_TVALID <= 1'b0;
      M00_AXIS_TDATA  <= '0;
      M00_AXIS_TID    <= '0;
      ptr_q           <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        M00_AXIS_TVALID <= 1'b1;
        M00_AXIS_TDATA  <= S00_AXIS_TDATA[grant];
        M00_AXIS_TID    <= ID_WIDTH'(grant);
        ptr_q           <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
      end else begin
        M00_AXIS_TVALID <= 1'b0;
      end
    end
  end

  // Saturating per-source counters; clear takes priority over an increment.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : gen_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge aclk) begin
      if (!resetn || stat_clear) begin
        cnt_q <= '0;
      end else if (accept && (grant == SEL_W'(i)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign cnt_all[i] = cnt_q;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      stat_count <= '0;
    end else if ({1'b0, stat_sel} < NUM_EXT) begin
      stat_count <= cnt_all[stat_sel[SEL_W-1:0]];
    end else begin
      stat_count <= '0;
    end
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Shares one 128-bit AXI-stream output between NUM_INPUTS aligned 128-bit streams, one beat at a time.
- Sits downstream of the per-group data-alignment FIFOs and feeds the single DMA/host stream.
- Grants by round robin, tags every output beat with its source index, and keeps per-source beat counters for the performance monitor.

Parameters:
- NUM_INPUTS, 4, number of requesting streams (2..16).
- DATA_WIDTH, 128, beat width in bits.
- ID_WIDTH, 4, width of M00_AXIS_TID; must satisfy 2**ID_WIDTH >= NUM_INPUTS.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- S00_AXIS_TVALID  in  [NUM_INPUTS-1:0]  per-source valid.
- S00_AXIS_TDATA  in  [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  per-source data.
- S00_AXIS_TREADY  out  [NUM_INPUTS-1:0]  per-source ready; one-hot or zero.
- M00_AXIS_TVALID  out  1  output valid.
- M00_AXIS_TDATA  out  DATA_WIDTH  output data.
- M00_AXIS_TID  out  ID_WIDTH  source index of the current output beat.
- M00_AXIS_TREADY  in  1  downstream ready.
- stat_sel  in  ID_WIDTH  selects which source beat counter is shown on stat_count.
- stat_clear  in  1  synchronous clear of all beat counters.
- stat_count  out  32  registered beat count of source stat_sel.

Behaviour:
- Reset (resetn=0 at a clock edge) clears:
  - M00_AXIS_TVALID, TDATA and TID to 0.
  - Priority pointer to 0.
  - All beat counters and stat_count to 0.
- While resetn=0, S00_AXIS_TREADY = 0.
- Reset mid-transfer drops the held output beat; it is not replayed.
- Output slice:
  - One register stage holds a single beat.
  - load_en = resetn & (!M00_AXIS_TVALID | M00_AXIS_TREADY).
- Grant (combinational):
  - Scan S00_AXIS_TVALID starting at the pointer, wrapping at NUM_INPUTS-1 back to 0.
  - The first asserted valid index is the grant; if none is asserted, there is no grant.
- S00_AXIS_TREADY[g] = load_en for the granted index g only; every other bit is 0.
- Transfer from source g when TVALID[g] & TREADY[g]. At the next edge:
  - M00_AXIS_TDATA <= S00_AXIS_TDATA[g], M00_AXIS_TID <= g, M00_AXIS_TVALID <= 1.
  - pointer <= (g == NUM_INPUTS-1) ? 0 : g+1.
- Latency: source acceptance to M00_AXIS_TVALID is 1 cycle.
- Throughput is 1 beat/cycle while M00_AXIS_TREADY=1 and any source is valid.
- If load_en=1 and no source is valid, M00_AXIS_TVALID <= 0. TDATA and TID hold their last values.
- While M00_AXIS_TVALID=1 and M00_AXIS_TREADY=0:
  - TDATA, TID and TVALID hold stable.
  - All S00_AXIS_TREADY = 0.
  - The pointer does not move.
- The grant is re-evaluated every cycle. A source deasserting TVALID before acceptance loses its turn and does not move the pointer.
- A single continuously valid source gets every beat, with no idle cycles.
- Beat counters (one 32-bit counter per source):
  - +1 on each accepted input beat from that source.
  - Saturate at 0xFFFF_FFFF.
  - stat_clear=1 zeroes all counters at the next edge; clear wins over a simultaneous increment.
- stat_count:
  - Registered each cycle as counter[stat_sel] (old value, before this edge's update).
  - stat_sel >= NUM_INPUTS gives 0.

Test Plan:
- Reset, then all 4 sources held valid with data 0x10+i and M00_AXIS_TREADY=1:
  - Output TID sequence 0,1,2,3,0,1,…
  - TVALID first rises 1 cycle after reset release.
  - No idle cycles.
- Only source 2 valid for 8 cycles, TREADY=1 → 8 consecutive beats with TID=2. Then source 2 drops and sources 1 and 3 go valid → next grant 3, then 1.
- Backpressure: M00_AXIS_TREADY=0 for 5 cycles while holding beat TID=1 data 0xAA → TDATA, TID and TVALID are stable and all S00_AXIS_TREADY=0. On TREADY=1, the next grant goes to source 2 (if valid).
- Counters: sources 0 and 3 stream 100 beats each → stat_sel=0 and stat_sel=3 read 100; stat_sel=1 reads 0; stat_sel=15 reads 0. stat_clear pulsed during a transfer → all counters 0 the following cycle.
- Saturation: force counter 0 to 0xFFFF_FFFE, then accept 3 beats from source 0 → counter reads 0xFFFF_FFFF.
- Reset mid-stream with a beat held and TREADY=0:
  - resetn=0 for 1 cycle gives TVALID=0, pointer=0 and counters 0.
  - After release, with all sources valid, the first grant is TID 0.
